// File: rtl/freq_meas_ctrl_if.sv
// Measurement/display bundle of the frequency-counter controller.
// The controller connects through the slave modport; the driver of sig_in/run
// (top level or bench) connects through the master modport.
interface freq_meas_ctrl_if;
  logic        sig_in;
  logic        run;
  logic        busy;
  logic        valid;
  logic [15:0] bcd_out;
  logic        ovf;
  logic [3:0]  scan_sel;
  logic [3:0]  scan_nib;
  logic        scan_blank;

  modport slave (
    input  sig_in,
    input  run,
    output busy,
    output valid,
    output bcd_out,
    output ovf,
    output scan_sel,
    output scan_nib,
    output scan_blank
  );

  modport master (
    output sig_in,
    output run,
    input  busy,
    input  valid,
    input  bcd_out,
    input  ovf,
    input  scan_sel,
    input  scan_nib,
    input  scan_blank
  );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Gated frequency measurement controller with a 4-digit BCD pulse counter
// and a time-multiplexed digit scan for one shared 7-segment decoder.
// Sequence: IDLE -> CLEAR -> GATE (GATE_CYCLES) -> LATCH -> HOLD (HOLD_CYCLES).
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zero digits
// (digit0 never, nothing while ovf=1). Without it scan_blank is tied 0.
module freq_meas_ctrl #(
  parameter int GATE_CYCLES = 50000000,
  parameter int HOLD_CYCLES = 5000000,
  parameter int SCAN_DIV    = 50000
) (
  input  logic            clk,
  input  logic            rst,
  freq_meas_ctrl_if.slave bus
);

  localparam int TMR_MAX = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_LATCH,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TMR_W-1:0]  r_tmr;
  logic              w_tmr_run;
  logic              w_clear;
  logic              w_count_en;
  logic              w_latch;
  logic              w_busy;

  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              w_edge;

  logic [15:0]       r_cnt;
  logic              r_ovf_int;
  logic [15:0]       r_bcd_out;
  logic              r_ovf;
  logic              r_valid;

  logic [DIV_W-1:0]  r_div;
  logic [1:0]        r_idx;
  logic [3:0]        r_scan_sel;
  logic [3:0]        r_scan_nib;
  logic              r_scan_blank;
  logic [3:0]        w_lz;

  // Decimal increment with per-digit carry; 9 wraps to 0 and carries up.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Input synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  // Measurement FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode; run is looked at only in IDLE and on the
  // last HOLD cycle, so dropping run mid-cycle still completes the latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_run   = 1'b0;
    w_clear     = 1'b0;
    w_count_en  = 1'b0;
    w_latch     = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.run) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_clear     = 1'b1;
        w_state_nxt = S_GATE;
      end
      S_GATE: begin
        w_tmr_run  = 1'b1;
        w_count_en = 1'b1;
        if (r_tmr == GATE_LAST) w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_latch     = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        w_tmr_run = 1'b1;
        if (r_tmr == HOLD_LAST) w_state_nxt = bus.run ? S_CLEAR : S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Window timer: restarts from 0 on every state change, counts in GATE/HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmr <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmr <= '0;
    end else if (w_tmr_run) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  // BCD pulse counter; saturates at 9999 and flags the overflow stickily.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= 16'h0000;
      r_ovf_int <= 1'b0;
    end else if (w_clear) begin
      r_cnt     <= 16'h0000;
      r_ovf_int <= 1'b0;
    end else if (w_count_en && w_edge) begin
      if (r_cnt == 16'h9999) begin
        r_ovf_int <= 1'b1;
      end else begin
        r_cnt <= bcd_inc(r_cnt);
      end
    end
  end

  // Result latch; valid rises in the same cycle the new bcd_out/ovf appear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd_out <= 16'h0000;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_latch;
      if (w_latch) begin
        r_bcd_out <= r_cnt;
        r_ovf     <= r_ovf_int;
      end
    end
  end

  // Free-running scan divider and digit index, independent of the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
      r_idx <= 2'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero mask: a digit blanks when it and all higher digits are 0.
  always_comb begin
    w_lz    = 4'b0000;
    w_lz[3] = !r_ovf && (r_bcd_out[15:12] == 4'd0);
    w_lz[2] = !r_ovf && (r_bcd_out[15:8]  == 8'd0);
    w_lz[1] = !r_ovf && (r_bcd_out[15:4]  == 12'd0);
  end
`else
  assign w_lz = 4'b0000;
`endif

  // Registered digit select, nibble and blank so all three change together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_sel   <= 4'b1110;
      r_scan_nib   <= 4'd0;
      r_scan_blank <= 1'b0;
    end else begin
      r_scan_sel   <= ~(4'b0001 << r_idx);
      r_scan_nib   <= r_bcd_out[{r_idx, 2'b00} +: 4];
      r_scan_blank <= w_lz[r_idx];
    end
  end

  assign bus.busy       = w_busy;
  assign bus.valid      = r_valid;
  assign bus.bcd_out    = r_bcd_out;
  assign bus.ovf        = r_ovf;
  assign bus.scan_sel   = r_scan_sel;
  assign bus.scan_nib   = r_scan_nib;
  assign bus.scan_blank = r_scan_blank;

endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
Controller that sequences a 4-digit BCD pulse counter through repeated gated frequency measurements: clear, count during a fixed gate window, latch, hold. It also time-multiplexes the latched digits onto one shared 7-segment decoder (BCD7-style, external) with active-low digit selects. It sits between the raw test-signal pin and the display path of the frequency-counter top level.

Parameters:
GATE_CYCLES, 50000000, clk cycles per gate window (1 s at 50 MHz); must be >= 2
HOLD_CYCLES, 5000000, clk cycles the result is held before the next measurement; must be >= 1
SCAN_DIV, 50000, clk cycles per display digit slot; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
sig_in  in  1  asynchronous test signal; rising edges are counted
run  in  1  1 = continuous measurement; 0 = stop after the current cycle
busy  out  1  1 in any state other than IDLE
valid  out  1  one-cycle pulse when bcd_out/ovf update
bcd_out  out  16  latched result, digit3 (thousands) at [15:12], digit0 (units) at [3:0]
ovf  out  1  latched overflow: more than 9999 edges occurred in the window
scan_sel  out  4  active-low one-hot digit enable, bit i = digit i
scan_nib  out  4  BCD nibble of the selected digit, to the external decoder
scan_blank  out  1  1 = decoder output must be forced blank for this slot

Behaviour:
- Reset (rst=0, async): FSM=IDLE, counters, bcd_out=16'h0000, ovf=0, valid=0, busy=0, scan index=0, scan_sel=4'b1110, scan_nib=0, scan_blank=0, synchronizer flops=0.
- Input sync: two-flop synchronizer s1->s2, plus a third flop s3. Edge pulse = s2 & ~s3. The edge is registered 3 clk after the sig_in rise.
- FSM states and transitions:
  - IDLE: run=1 -> CLEAR.
  - CLEAR: 1 cycle. BCD counter=0, ovf_int=0 -> GATE.
  - GATE: exactly GATE_CYCLES cycles. An edge pulse in any GATE cycle increments the BCD counter -> LATCH.
  - LATCH: 1 cycle. bcd_out<=counter, ovf<=ovf_int, valid=1 for this cycle only -> HOLD.
  - HOLD: HOLD_CYCLES cycles, then run=1 -> CLEAR, run=0 -> IDLE.
- run is sampled only in IDLE and at the last HOLD cycle. Deasserting run mid-measurement completes the cycle and its latch.
- Edges outside GATE are ignored.
- BCD counting: per-digit decimal carry; 9 -> 0 with carry into the next digit.
- At 9999, a further edge leaves the counter at 9999 (saturates) and sets ovf_int. ovf_int is sticky until CLEAR.
- bcd_out/ovf change only in LATCH; they are stable through HOLD, IDLE and the next GATE.
- Scan: free-running divider 0..SCAN_DIV-1. At SCAN_DIV-1 the index advances 0->1->2->3->0. Scan runs in every state, including IDLE.
- scan_sel = ~(1<<index); scan_nib = bcd_out digit[index]. Both are registered and update together.
- scan_blank = 0 unless the optional feature is enabled.
- Async reset mid-GATE aborts the measurement; the first measurement after reset starts from IDLE.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: scan_blank=1 for digit i (i=3..1) when digit i and every higher digit of bcd_out are 0. Digit0 is never blanked. When ovf=1, no digit is blanked.
- Undefined: scan_blank is tied 0.
- scan_sel/scan_nib timing is identical in both builds.

Test Plan:
- GATE=20, HOLD=4, SCAN_DIV=2, run=1, sig_in period 4 clk -> valid pulses every 26 clk (CLEAR+GATE+LATCH+HOLD); bcd_out=16'h0005, ovf=0.
- sig_in toggled every clk (period 2), GATE=20 -> bcd_out=16'h0010, checks decimal carry 9->10.
- GATE=25000, sig period 2 (12500 edges) -> bcd_out=16'h9999, ovf=1; next window with sig held low -> bcd_out=0000, ovf=0.
- run dropped during GATE -> that result still latches with valid=1, FSM returns to IDLE, busy=0, no further valid pulses; re-raise run -> CLEAR the next cycle.
- SCAN_DIV=2, bcd_out=16'h1234 -> scan_sel 1110/1101/1011/0111 every 2 clk with scan_nib 4/3/2/1. With LEADING_ZERO_BLANK_EN and bcd_out=16'h0040: scan_blank 0,0,1,1 for digits 0..3.
- rst pulsed low mid-GATE -> all outputs at reset values immediately (async); measurement restarts cleanly from IDLE.
